// File: rtl/mu0_reg_bank_if.sv
// Bus interface for mu0_reg_bank: one write port with an operation selector, two
// read ports, and the registered Zero/Carry flags. Clock and reset are not carried here.
interface mu0_reg_bank_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             En;
    logic [1:0]       Op;
    logic [AW-1:0]    WAddr;
    logic [WIDTH-1:0] D;
    logic [AW-1:0]    RAddrA;
    logic [AW-1:0]    RAddrB;
    logic [WIDTH-1:0] QA;
    logic [WIDTH-1:0] QB;
    logic             Zero;
    logic             Carry;

    modport master (
        output En, Op, WAddr, D, RAddrA, RAddrB,
        input  QA, QB, Zero, Carry
    );

    modport slave (
        input  En, Op, WAddr, D, RAddrA, RAddrB,
        output QA, QB, Zero, Carry
    );
endinterface

// File: rtl/mu0_reg_bank.sv
// mu0_reg_bank: DEPTH x WIDTH register bank for the MU0 datapath.
// One write port executes LOAD / INC / DEC / CLR on register WAddr, two combinational
// read ports, registered Zero/Carry flags describing the last executed write.
// Out-of-range write addresses are ignored; out-of-range read addresses return 0.
// Optional macro MU0_REG_BANK_BYPASS_EN forwards the pending write value to a read
// port addressing the register being written (write-to-read latency 0 instead of 1).
module mu0_reg_bank #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    mu0_reg_bank_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_zero;
    logic             r_carry;

    logic             w_wr_hit;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_next;
    logic             w_carry_nx;
    logic [WIDTH-1:0] w_qa;
    logic [WIDTH-1:0] w_qb;

    // Decode the write address and compute the next value and carry for the target register
    always_comb begin
        w_wr_hit   = 1'b0;
        w_cur      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.WAddr == AW'(i)) begin
                w_wr_hit = 1'b1;
                w_cur    = r_mem[i];
            end
        end
        w_wr_en    = bus.En & w_wr_hit;
        w_next     = '0;
        w_carry_nx = 1'b0;
        case (bus.Op)
            OP_LOAD: w_next = bus.D;
            OP_INC: begin
                w_next     = w_cur + WIDTH'(1);
                w_carry_nx = &w_cur;
            end
            OP_DEC: begin
                w_next     = w_cur - WIDTH'(1);
                w_carry_nx = ~|w_cur;
            end
            OP_CLR:  w_next = '0;
            default: w_next = '0;
        endcase
    end

    // Read port A: stored contents, optionally overridden by the pending write value
    always_comb begin
        w_qa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.RAddrA == AW'(i)) w_qa = r_mem[i];
        end
`ifdef MU0_REG_BANK_BYPASS_EN
        if (Reset && w_wr_en && (bus.RAddrA == bus.WAddr)) w_qa = w_next;
`endif
    end

    // Read port B: same structure as port A, fully independent address
    always_comb begin
        w_qb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.RAddrB == AW'(i)) w_qb = r_mem[i];
        end
`ifdef MU0_REG_BANK_BYPASS_EN
        if (Reset && w_wr_en && (bus.RAddrB == bus.WAddr)) w_qb = w_next;
`endif
    end

    // Register array and flags; async reset clears everything and beats any write
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.WAddr == AW'(i)) r_mem[i] <= w_next;
            end
            r_zero  <= (w_next == '0);
            r_carry <= w_carry_nx;
        end
    end

    assign bus.QA    = w_qa;
    assign bus.QB    = w_qb;
    assign bus.Zero  = r_zero;
    assign bus.Carry = r_carry;
endmodule
